uart_frame_ctrl: RTL and testbench

Frame controller that sequences the byte stream from the UART receiver into the BNN image buffer. It hunts for a sync byte, then writes a fixed-length payload into the buffer. It optionally verifies an XOR checksum and signals the BNN core when a complete image is loaded. It also owns RTS flow control toward the host and counts framing, timeout and checksum errors.

---
 rtl/uart_bnn_pkg.sv | 24 ++
 rtl/uart_idle_timer.sv | 30 +++
 rtl/uart_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_frame_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bnn_pkg.sv
// Shared types and constants for the UART-to-BNN frame path.
// The optional checksum stage is selected with UART_FRAME_CKSUM_EN.
package uart_bnn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      DONE    = 2'd3
   } frame_state_t;

   localparam logic [7:0]  SYNC_BYTE_DFLT = 8'hA5;
   localparam int unsigned ERR_CNT_W      = 8;

   function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   // Host may send while hunting (unless the core holds the buffer) or mid-frame.
   function automatic logic rts_for(input frame_state_t s, input logic busy);
      return ((s == IDLE) && !busy) || (s == PAYLOAD) || (s == CHECK);
   endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer for uart_frame_ctrl; counts idle baud_clk edges
// while enabled and flags expiry on the cycle ending in the TIMEOUT_CYC-th one.
module uart_idle_timer #(
   parameter int unsigned TIMEOUT_CYC = 40
) (
   input  logic baud_clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned   CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] count;

   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear || !enable)
         count <= '0;
      else if (count != LAST)
         count <= count + 1'b1;
   end

   // Count holds idle edges already seen, so the next idle edge is the expiring one.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Sequences UART bytes into the BNN image buffer: sync hunt, payload write,
// optional XOR checksum (UART_FRAME_CKSUM_EN), RTS flow control, error count.
module uart_frame_ctrl
   import uart_bnn_pkg::*;
#(
   parameter  int unsigned IMG_BYTES   = 13,
   parameter  int unsigned TIMEOUT_CYC = 40,
   parameter  logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DFLT,
   localparam int unsigned AW          = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1
) (
   input  logic                 baud_clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   input  logic                 rx_err,
   input  logic                 bnn_busy,
   output logic                 rts,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [7:0]           wr_data,
   output logic                 img_ready,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [AW-1:0] LAST_IDX = AW'(IMG_BYTES - 1);

   frame_state_t  state;
   logic [AW-1:0] idx;
   logic          in_frame;
   logic          tmr_expired;
   logic          abort;
   logic          err_bump;
`ifdef UART_FRAME_CKSUM_EN
   logic [7:0]    cksum;
`endif

   assign in_frame = (state == PAYLOAD) || (state == CHECK);

   uart_idle_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_idle_timer (
      .baud_clk(baud_clk),
      .rst     (rst),
      .clear   (rx_valid),
      .enable  (in_frame),
      .expired (tmr_expired)
   );

   // rx_err beats a coincident byte; a byte beats a coincident timer expiry.
   always_comb begin
      abort = in_frame && (rx_err || (!rx_valid && tmr_expired));
`ifdef UART_FRAME_CKSUM_EN
      if ((state == CHECK) && rx_valid && (rx_data != cksum))
         abort = 1'b1;
`endif
      err_bump = rx_err || abort;
   end

   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         rts       <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         img_ready <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= '0;
`ifdef UART_FRAME_CKSUM_EN
         cksum     <= '0;
`endif
      end else begin
         wr_en     <= 1'b0;
         img_ready <= 1'b0;
         frame_err <= 1'b0;
         rts       <= rts_for(state, bnn_busy);

         if (err_bump)
            err_cnt <= err_sat_inc(err_cnt);

         if (abort) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            rts       <= rts_for(IDLE, bnn_busy);
         end else begin
            case (state)
               IDLE: begin
                  if (rx_valid && !rx_err && (rx_data == SYNC_BYTE) && !bnn_busy) begin
                     state <= PAYLOAD;
                     idx   <= '0;
                     rts   <= rts_for(PAYLOAD, bnn_busy);
`ifdef UART_FRAME_CKSUM_EN
                     cksum <= '0;
`endif
                  end
               end
               PAYLOAD: begin
                  if (rx_valid) begin
                     wr_en   <= 1'b1;
                     wr_addr <= idx;
                     wr_data <= rx_data;
                     idx     <= idx + 1'b1;
`ifdef UART_FRAME_CKSUM_EN
                     cksum   <= cksum ^ rx_data;
                     if (idx == LAST_IDX)
                        state <= CHECK;
`else
                     if (idx == LAST_IDX) begin
                        state     <= DONE;
                        img_ready <= 1'b1;
                        rts       <= 1'b0;
                     end
`endif
                  end
               end
`ifdef UART_FRAME_CKSUM_EN
               CHECK: begin
                  if (rx_valid) begin
                     state     <= DONE;
                     img_ready <= 1'b1;
                     rts       <= 1'b0;
                  end
               end
`endif
               DONE: begin
                  state <= IDLE;
                  rts   <= rts_for(IDLE, bnn_busy);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl (IMG_BYTES=4); covers both
// UART_FRAME_CKSUM_EN builds with a frame-position reference model.
module tb_uart_frame_ctrl;

   localparam int         IMG  = 4;
   localparam int         TMO  = 40;
   localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_FRAME_CKSUM_EN
   localparam int         CK   = 1;
`else
   localparam int         CK   = 0;
`endif

   logic       baud_clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       bnn_busy;
   logic       rts;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       img_ready;
   logic       frame_err;
   logic [7:0] err_cnt;

   always #5 baud_clk = ~baud_clk;

   uart_frame_ctrl #(
      .IMG_BYTES  (IMG),
      .TIMEOUT_CYC(TMO),
      .SYNC_BYTE  (SYNC)
   ) dut (
      .baud_clk (baud_clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .bnn_busy (bnn_busy),
      .rts      (rts),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .img_ready(img_ready),
      .frame_err(frame_err),
      .err_cnt  (err_cnt)
   );

   int n_checks;
   int n_errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: m_pos is the position in the frame (-1 while hunting,
   // 0..IMG-1 next payload byte, IMG awaiting checksum); m_idle counts quiet edges.
   int         m_pos;
   bit         m_done;
   int         m_idle;
   int         m_err;
   logic [7:0] m_xor;
   bit         e_wr, e_img, e_ferr, e_rts;
   int         e_addr;
   logic [7:0] e_data;

   function automatic int sat_inc(input int c);
      return (c < 255) ? c + 1 : 255;
   endfunction

   function automatic void model_reset();
      m_pos = -1; m_done = 0; m_idle = 0; m_err = 0; m_xor = '0;
      e_wr = 0; e_img = 0; e_ferr = 0; e_rts = 0; e_addr = 0; e_data = '0;
   endfunction

   function automatic void model_step(input bit v, input logic [7:0] d, input bit e, input bit busy);
      bit abort_f  = 0;
      bit finish_f = 0;
      e_wr = 0; e_img = 0; e_ferr = 0;
      if (m_done) begin
         m_done = 0;
         if (e) m_err = sat_inc(m_err);
      end else if (m_pos < 0) begin
         if (e) m_err = sat_inc(m_err);
         else if (v && d == SYNC && !busy) begin
            m_pos = 0; m_idle = 0; m_xor = '0;
         end
      end else if (e) begin
         abort_f = 1;
      end else if (v) begin
         m_idle = 0;
         if (m_pos < IMG) begin
            e_wr = 1; e_addr = m_pos; e_data = d;
            m_xor = m_xor ^ d;
            m_pos++;
            if (CK == 0 && m_pos == IMG) finish_f = 1;
         end else if (d == m_xor) finish_f = 1;
         else abort_f = 1;
      end else begin
         m_idle++;
         if (m_idle >= TMO) abort_f = 1;
      end
      if (abort_f) begin
         e_ferr = 1; m_err = sat_inc(m_err); m_pos = -1;
      end
      if (finish_f) begin
         e_img = 1; m_done = 1; m_pos = -1;
      end
      e_rts = m_done ? 1'b0 : ((m_pos < 0) ? !busy : 1'b1);
   endfunction

   task automatic check_model();
      chk("wr_en", wr_en, e_wr);
      chk("img_ready", img_ready, e_img);
      chk("frame_err", frame_err, e_ferr);
      chk("rts", rts, e_rts);
      chk("err_cnt", err_cnt, m_err);
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit e, input bit busy);
      rx_valid = v; rx_data = d; rx_err = e; bnn_busy = busy;
      @(posedge baud_clk);
      model_step(v, d, e, busy);
      #1;
      rx_valid = 1'b0; rx_err = 1'b0;
   endtask

   task automatic step_m(input bit v, input logic [7:0] d, input bit e, input bit busy);
      cycle(v, d, e, busy);
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0; bnn_busy = 1'b0;
      @(posedge baud_clk);
      #1;
      model_reset();
      check_model();
      rst = 1'b0;
   endtask

   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         e;
      bit         busy;
      bit         x_wr;
      logic [1:0] x_addr;
      logic [7:0] x_data;
      bit         x_img;
      bit         x_ferr;
      logic [7:0] x_cnt;
      bit         x_rts;
   } vec_t;

   vec_t tbl[$];

   function automatic void add_vec(input bit v, input logic [7:0] d, input bit e, input bit busy,
                                   input bit xw, input logic [1:0] xa, input logic [7:0] xd,
                                   input bit ximg, input bit xferr, input logic [7:0] xcnt,
                                   input bit xrts);
      vec_t r;
      r.v = v; r.d = d; r.e = e; r.busy = busy;
      r.x_wr = xw; r.x_addr = xa; r.x_data = xd; r.x_img = ximg;
      r.x_ferr = xferr; r.x_cnt = xcnt; r.x_rts = xrts;
      tbl.push_back(r);
   endfunction

   task automatic gap(input int n, input bit busy);
      for (int i = 0; i < n; i++)
         step_m(1'b0, 8'($urandom), ($urandom_range(0, 149) == 0), busy);
   endtask

   task automatic send(input logic [7:0] d, input bit busy);
      step_m(1'b1, d, ($urandom_range(0, 49) == 0), busy);
   endtask

   task automatic rand_phase();
      bit         busy = 1'b0;
      logic [7:0] x;
      logic [7:0] b;
      int         g;
      for (int f = 0; f < 200; f++) begin
         if ($urandom_range(0, 3) == 0) busy = ~busy;
         gap(int'($urandom_range(0, 3)), busy);
         send(($urandom_range(0, 7) == 0) ? 8'($urandom) : SYNC, busy);
         x = '0;
         for (int i = 0; i < IMG + CK; i++) begin
            g = ($urandom_range(0, 11) == 0) ? int'($urandom_range(TMO - 3, TMO + 3))
                                             : int'($urandom_range(0, 2));
            gap(g, busy);
            if ($urandom_range(0, 5) == 0) busy = ~busy;
            b = 8'($urandom);
            if (i == IMG && $urandom_range(0, 3) != 0) b = x;
            if (i < IMG) x = x ^ b;
            send(b, busy);
         end
      end
      gap(5, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0; bnn_busy = 1'b0;
      repeat (2) @(posedge baud_clk);
      #1;
      model_reset();
      check_model();
      rst = 1'b0;
      step_m(1'b0, 8'h00, 1'b0, 1'b0);
      chk("rts_after_reset", rts, 1);

      // Good frame, flow control and idle rx_err, against fixed expectations.
      add_vec(0, 8'h00, 0, 0,  0, 0, 8'h00,  0, 0, 8'd0, 1);
      add_vec(0, 8'h00, 0, 1,  0, 0, 8'h00,  0, 0, 8'd0, 0);
      add_vec(1, 8'hA5, 0, 1,  0, 0, 8'h00,  0, 0, 8'd0, 0);
      add_vec(1, 8'h01, 0, 0,  0, 0, 8'h00,  0, 0, 8'd0, 1);
      add_vec(0, 8'h00, 1, 0,  0, 0, 8'h00,  0, 0, 8'd1, 1);
      add_vec(1, 8'hA5, 0, 0,  0, 0, 8'h00,  0, 0, 8'd1, 1);
      add_vec(1, 8'h01, 0, 0,  1, 0, 8'h01,  0, 0, 8'd1, 1);
      add_vec(1, 8'h02, 0, 0,  1, 1, 8'h02,  0, 0, 8'd1, 1);
      add_vec(1, 8'h03, 0, 1,  1, 2, 8'h03,  0, 0, 8'd1, 1);
`ifdef UART_FRAME_CKSUM_EN
      add_vec(1, 8'h04, 0, 1,  1, 3, 8'h04,  0, 0, 8'd1, 1);
      add_vec(1, 8'h04, 0, 1,  0, 0, 8'h00,  1, 0, 8'd1, 0);
`else
      add_vec(1, 8'h04, 0, 1,  1, 3, 8'h04,  1, 0, 8'd1, 0);
`endif
      add_vec(0, 8'h00, 0, 1,  0, 0, 8'h00,  0, 0, 8'd1, 0);
      add_vec(0, 8'h00, 0, 0,  0, 0, 8'h00,  0, 0, 8'd1, 1);

      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].busy);
         chk($sformatf("tbl%0d.wr_en", i), wr_en, tbl[i].x_wr);
         if (tbl[i].x_wr) begin
            chk($sformatf("tbl%0d.wr_addr", i), wr_addr, tbl[i].x_addr);
            chk($sformatf("tbl%0d.wr_data", i), wr_data, tbl[i].x_data);
         end
         chk($sformatf("tbl%0d.img_ready", i), img_ready, tbl[i].x_img);
         chk($sformatf("tbl%0d.frame_err", i), frame_err, tbl[i].x_ferr);
         chk($sformatf("tbl%0d.err_cnt", i), err_cnt, tbl[i].x_cnt);
         chk($sformatf("tbl%0d.rts", i), rts, tbl[i].x_rts);
      end

      // Checksum byte wrong (or a trailing stray byte when there is no checksum).
      do_reset();
      step_m(1, 8'hA5, 0, 0);
      step_m(1, 8'h01, 0, 0);
      step_m(1, 8'h02, 0, 0);
      step_m(1, 8'h03, 0, 0);
      step_m(1, 8'h04, 0, 0);
      step_m(1, 8'hFF, 0, 0);
`ifdef UART_FRAME_CKSUM_EN
      chk("badck_frame_err", frame_err, 1);
      chk("badck_img_ready", img_ready, 0);
      chk("badck_err_cnt", err_cnt, 1);
`else
      chk("stray_frame_err", frame_err, 0);
      chk("stray_err_cnt", err_cnt, 0);
`endif
      step_m(0, 8'h00, 0, 0);
      chk("badck_idle_rts", rts, 1);

      // Timeout after 40 quiet cycles, then a clean frame.
      do_reset();
      step_m(1, 8'hA5, 0, 0);
      step_m(1, 8'h01, 0, 0);
      for (int i = 0; i < TMO - 1; i++) step_m(0, 8'h00, 0, 0);
      chk("tmo_not_yet", frame_err, 0);
      step_m(0, 8'h00, 0, 0);
      chk("tmo_frame_err", frame_err, 1);
      chk("tmo_err_cnt", err_cnt, 1);
      step_m(1, 8'hA5, 0, 0);
      for (int i = 1; i <= IMG; i++) step_m(1, 8'(i), 0, 0);
      if (CK != 0) step_m(1, 8'h04, 0, 0);
      chk("tmo_reload_img", img_ready, 1);

      // A byte landing on the expiry edge is kept.
      do_reset();
      step_m(1, 8'hA5, 0, 0);
      step_m(1, 8'h11, 0, 0);
      for (int i = 0; i < TMO - 1; i++) step_m(0, 8'h00, 0, 0);
      step_m(1, 8'h22, 0, 0);
      chk("expiry_byte_wr_en", wr_en, 1);
      chk("expiry_byte_data", wr_data, 8'h22);
      chk("expiry_byte_ferr", frame_err, 0);

      // rx_err together with the third payload byte.
      do_reset();
      step_m(1, 8'hA5, 0, 0);
      step_m(1, 8'h01, 0, 0);
      step_m(1, 8'h02, 0, 0);
      step_m(1, 8'h03, 1, 0);
      chk("rxerr_wr_en", wr_en, 0);
      chk("rxerr_frame_err", frame_err, 1);
      chk("rxerr_err_cnt", err_cnt, 1);

      // Error counter saturation.
      do_reset();
      for (int i = 0; i < 300; i++) step_m(0, 8'h00, 1, 0);
      chk("sat_err_cnt", err_cnt, 255);

      // Asynchronous reset in the middle of a frame.
      step_m(1, 8'hA5, 0, 0);
      step_m(1, 8'h01, 0, 0);
      step_m(1, 8'h02, 0, 0);
      rst = 1'b1;
      #2;
      chk("rstmid_wr_en", wr_en, 0);
      chk("rstmid_wr_addr", wr_addr, 0);
      chk("rstmid_wr_data", wr_data, 0);
      chk("rstmid_rts", rts, 0);
      chk("rstmid_img_ready", img_ready, 0);
      chk("rstmid_frame_err", frame_err, 0);
      chk("rstmid_err_cnt", err_cnt, 0);
      @(posedge baud_clk);
      #1;
      model_reset();
      rst = 1'b0;
      step_m(1, 8'h03, 0, 0);
      step_m(1, 8'h04, 0, 0);
      chk("rstmid_no_resume", wr_en, 0);

      do_reset();
      rand_phase();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
